writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 101 ++++++++++
 tb/tb_writeback_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter that merges RequesterCount writeback sources onto one register-file write port.
// Optional build macro WRITEBACK_ARBITER_X0_FILTER_EN: x0 writes are absorbed without using the port.
package writeback_arbiter_pkg;
  typedef struct packed {
    logic        enable;
    logic [4:0]  address;
    logic [31:0] data;
  } register_file_write_t;
endpackage

module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int RequesterCount = 3
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [RequesterCount-1:0]              req_valid_i,
  output logic [RequesterCount-1:0]              req_ready_o,
  input  logic [RequesterCount-1:0][4:0]         req_address_i,
  input  logic [RequesterCount-1:0][31:0]        req_data_i,
  input  logic                                   stall_i,
  output register_file_write_t                   write_o,
  output logic [$clog2(RequesterCount)-1:0]      grant_index_o
);
  localparam int IdxW = $clog2(RequesterCount);

  logic [RequesterCount-1:0] arb_req;
  logic [RequesterCount-1:0] bypass_ready;
  logic [IdxW-1:0]           rr_ptr_reg, rr_ptr_next;
  logic [IdxW-1:0]           winner;
  logic                      win_found;
  logic                      accept;
  logic [IdxW:0]             scan_idx;
  register_file_write_t      write_reg, write_next;
  logic [IdxW-1:0]           grant_reg, grant_next;

  genvar gi;
  generate
    for (gi = 0; gi < RequesterCount; gi++) begin : g_src
`ifdef WRITEBACK_ARBITER_X0_FILTER_EN
      // x0 writes are acknowledged on the spot and never reach the port
      assign arb_req[gi]      = req_valid_i[gi] && (req_address_i[gi] != 5'd0);
      assign bypass_ready[gi] = req_valid_i[gi] && (req_address_i[gi] == 5'd0);
`else
      assign arb_req[gi]      = req_valid_i[gi];
      assign bypass_ready[gi] = 1'b0;
`endif
      assign req_ready_o[gi] = !stall_i && !rst_i &&
                               (bypass_ready[gi] || (win_found && (winner == IdxW'(gi))));
    end
  endgenerate

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    scan_idx  = '0;
    for (int k = RequesterCount - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr_reg} + (IdxW+1)'(k);
      if (scan_idx >= (IdxW+1)'(RequesterCount)) begin
        scan_idx = scan_idx - (IdxW+1)'(RequesterCount);
      end
      if (arb_req[scan_idx[IdxW-1:0]]) begin
        win_found = 1'b1;
        winner    = scan_idx[IdxW-1:0];
      end
    end
  end

  assign accept = win_found && !stall_i;

  always_comb begin
    write_next  = '0;
    grant_next  = '0;
    rr_ptr_next = rr_ptr_reg;
    if (accept) begin
      write_next.enable  = 1'b1;
      write_next.address = req_address_i[winner];
      write_next.data    = req_data_i[winner];
      grant_next         = winner;
      rr_ptr_next        = (winner == IdxW'(RequesterCount - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_reg <= '0;
      write_reg  <= '0;
      grant_reg  <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      write_reg  <= write_next;
      grant_reg  <= grant_next;
    end
  end

  assign write_o       = write_reg;
  assign grant_index_o = grant_reg;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus randomized stress against a queue-based model.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int GW = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 stall;
  logic [N-1:0]         valid;
  logic [N-1:0]         ready;
  logic [N-1:0][4:0]    addr;
  logic [N-1:0][31:0]   data;
  register_file_write_t write_o;
  logic [GW-1:0]        gnt;

  int checks = 0;
  int passes = 0;

  // Model state
  int          m_ptr = 0;
  logic        exp_en = 1'b0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  int          exp_gnt = 0;

  writeback_arbiter #(.RequesterCount(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (valid),
    .req_ready_o  (ready),
    .req_address_i(addr),
    .req_data_i   (data),
    .stall_i      (stall),
    .write_o      (write_o),
    .grant_index_o(gnt)
  );

  always #5 clk = ~clk;

  function automatic bit competes(int i);
`ifdef WRITEBACK_ARBITER_X0_FILTER_EN
    return valid[i] && (addr[i] != 5'd0);
`else
    return valid[i];
`endif
  endfunction

  function automatic int model_winner();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (competes(i)) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    if (rst || stall) return r;
    w = model_winner();
    if (w >= 0) r[w] = 1'b1;
`ifdef WRITEBACK_ARBITER_X0_FILTER_EN
    for (int i = 0; i < N; i++) if (valid[i] && addr[i] == 5'd0) r[i] = 1'b1;
`endif
    return r;
  endfunction

  // Advance one clock and update the model's expected registered outputs.
  task automatic tick();
    int w;
    w = model_winner();
    @(posedge clk);
    if (rst || stall || w < 0) begin
      exp_en = 1'b0; exp_addr = '0; exp_data = '0; exp_gnt = 0;
      if (rst) m_ptr = 0;
    end else begin
      exp_en = 1'b1; exp_addr = addr[w]; exp_data = data[w]; exp_gnt = w;
      m_ptr = (w + 1) % N;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; valid = '0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; valid = '1;
    for (int i = 0; i < N; i++) begin
      addr[i] = 5'($urandom_range(0, 31));
      data[i] = $urandom;
    end
    #1;
    checks++;
    if (ready !== '0) $display("FAIL reset_ready: got %b expected %b", ready, {N{1'b0}});
    else passes++;
    tick(); tick();
    checks++;
    if (write_o !== '0) $display("FAIL reset_write: got %h expected 0", write_o);
    else passes++;
    checks++;
    if (gnt !== '0) $display("FAIL reset_grant: got %0d expected 0", gnt);
    else passes++;
    rst = 1'b0; valid = '0;
    tick();
    checks++;
    if (write_o !== '0 || gnt !== '0) $display("FAIL idle_write: got %h/%0d expected 0/0", write_o, gnt);
    else passes++;
  endtask

  task automatic test_single();
    do_reset();
    valid = 3'b010; addr[1] = 5'd5; data[1] = 32'hDEADBEEF;
    #1;
    checks++;
    if (ready !== 3'b010) $display("FAIL single_ready: got %b expected 010", ready);
    else passes++;
    tick();
    valid = '0;
    checks++;
    if (write_o !== {1'b1, 5'd5, 32'hDEADBEEF}) $display("FAIL single_write: got %h expected 1/05/deadbeef", write_o);
    else passes++;
    checks++;
    if (gnt !== GW'(1)) $display("FAIL single_grant: got %0d expected 1", gnt);
    else passes++;
    tick();
    checks++;
    if (write_o.enable !== 1'b0) $display("FAIL single_idle: got %b expected 0", write_o.enable);
    else passes++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] oh;
    do_reset();
    valid = '1;
    for (int i = 0; i < N; i++) begin
      addr[i] = 5'(10 + i);
      data[i] = 32'hA000_0000 + 32'(i);
    end
    #1;
    for (int k = 0; k < 6; k++) begin
      int e;
      e = k % N;
      oh = '0; oh[e] = 1'b1;
      checks++;
      if (ready !== oh) $display("FAIL rr_ready[%0d]: got %b expected %b", k, ready, oh);
      else passes++;
      tick();
      checks++;
      if (write_o !== {1'b1, 5'(10 + e), 32'hA000_0000 + 32'(e)} || gnt !== GW'(e))
        $display("FAIL rr_write[%0d]: got %h/%0d expected src %0d", k, write_o, gnt, e);
      else passes++;
    end
    valid = '0;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    valid = 3'b100; addr[2] = 5'd3; data[2] = 32'h2222_0001;
    #1;
    tick();
    stall = 1'b1; valid = 3'b101;
    addr[0] = 5'd1; data[0] = 32'h0000_0011;
    addr[2] = 5'd4; data[2] = 32'h2222_0002;
    #1;
    for (int s = 1; s <= 4; s++) begin
      checks++;
      if (ready !== 3'b000) $display("FAIL stall_ready[%0d]: got %b expected 000", s, ready);
      else passes++;
      checks++;
      if (write_o.enable !== (s == 1)) $display("FAIL stall_write[%0d]: got %b expected %b", s, write_o.enable, s == 1);
      else passes++;
      tick();
    end
    checks++;
    if (write_o.enable !== 1'b0) $display("FAIL stall_tail: got %b expected 0", write_o.enable);
    else passes++;
    stall = 1'b0;
    #1;
    checks++;
    if (ready !== 3'b001) $display("FAIL stall_release0: got %b expected 001", ready);
    else passes++;
    tick();
    checks++;
    if (write_o !== {1'b1, 5'd1, 32'h0000_0011} || gnt !== GW'(0)) $display("FAIL stall_grant0: got %h/%0d expected src 0", write_o, gnt);
    else passes++;
    valid[0] = 1'b0;
    #1;
    checks++;
    if (ready !== 3'b100) $display("FAIL stall_release2: got %b expected 100", ready);
    else passes++;
    tick();
    checks++;
    if (write_o !== {1'b1, 5'd4, 32'h2222_0002} || gnt !== GW'(2)) $display("FAIL stall_grant2: got %h/%0d expected src 2", write_o, gnt);
    else passes++;
    valid = '0;
    tick();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    valid = 3'b010; addr[1] = 5'd6; data[1] = 32'h1111_0006;
    #1;
    tick();
    valid = 3'b101; addr[0] = 5'd8; data[0] = 32'h0000_0008; addr[2] = 5'd9; data[2] = 32'h2222_0009;
    #1;
    checks++;
    if (ready !== 3'b100) $display("FAIL mid_pre_ready: got %b expected 100", ready);
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 3'b000) $display("FAIL mid_rst_ready: got %b expected 000", ready);
    else passes++;
    tick();
    checks++;
    if (write_o !== '0 || gnt !== '0) $display("FAIL mid_no_pulse: got %h/%0d expected 0/0", write_o, gnt);
    else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if (ready !== 3'b001) $display("FAIL mid_resume_ready: got %b expected 001", ready);
    else passes++;
    tick();
    checks++;
    if (write_o !== {1'b1, 5'd8, 32'h0000_0008} || gnt !== GW'(0)) $display("FAIL mid_resume_write: got %h/%0d expected src 0", write_o, gnt);
    else passes++;
    valid = '0;
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    valid = 3'b011;
    addr[0] = 5'd0; data[0] = 32'h0000_00AA;
    addr[1] = 5'd7; data[1] = 32'h1111_00BB;
    #1;
`ifdef WRITEBACK_ARBITER_X0_FILTER_EN
    checks++;
    if (ready !== 3'b011) $display("FAIL x0_ready: got %b expected 011", ready);
    else passes++;
    tick();
    checks++;
    if (write_o !== {1'b1, 5'd7, 32'h1111_00BB} || gnt !== GW'(1)) $display("FAIL x0_write: got %h/%0d expected src 1", write_o, gnt);
    else passes++;
    valid = 3'b101; addr[0] = 5'd3; addr[2] = 5'd4;
    #1;
    checks++;
    if (ready !== 3'b100) $display("FAIL x0_ptr: got %b expected 100", ready);
    else passes++;
    valid = 3'b001; addr[0] = 5'd0;
    #1;
    checks++;
    if (ready !== 3'b001) $display("FAIL x0_alone_ready: got %b expected 001", ready);
    else passes++;
    tick();
    checks++;
    if (write_o.enable !== 1'b0) $display("FAIL x0_alone_write: got %b expected 0", write_o.enable);
    else passes++;
`else
    checks++;
    if (ready !== 3'b001) $display("FAIL x0_ready: got %b expected 001", ready);
    else passes++;
    tick();
    checks++;
    if (write_o !== {1'b1, 5'd0, 32'h0000_00AA} || gnt !== GW'(0)) $display("FAIL x0_write: got %h/%0d expected src 0 addr 0", write_o, gnt);
    else passes++;
    valid = 3'b010;
    #1;
    checks++;
    if (ready !== 3'b010) $display("FAIL x0_next_ready: got %b expected 010", ready);
    else passes++;
    tick();
    checks++;
    if (write_o !== {1'b1, 5'd7, 32'h1111_00BB} || gnt !== GW'(1)) $display("FAIL x0_next_write: got %h/%0d expected src 1", write_o, gnt);
    else passes++;
`endif
    valid = '0;
    tick();
  endtask

  task automatic test_random();
    logic [31:0]  q [N][$];
    logic [N-1:0] pending;
    logic [N-1:0] exp_r;
    int           wait_cnt [N];
    int           max_wait;
    int           seq;
    do_reset();
    pending = '0; max_wait = 0; seq = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(0, 1) == 1) begin
          pending[i] = 1'b1;
          addr[i]    = 5'($urandom_range(1, 31));
          data[i]    = {8'(i), 24'(seq)};
          seq++;
          q[i].push_back(data[i]);
        end
      end
      valid = pending;
      stall = ($urandom_range(0, 3) == 0);
      #1;
      exp_r = model_ready();
      checks++;
      if (ready !== exp_r) $display("FAIL rnd_ready[%0d]: got %b expected %b", cyc, ready, exp_r);
      else passes++;
      for (int i = 0; i < N; i++) begin
        if (pending[i] && exp_r[i]) begin
          pending[i]  = 1'b0;
          wait_cnt[i] = 0;
        end else if (pending[i] && exp_r != '0) begin
          wait_cnt[i]++;
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
      end
      tick();
      checks++;
      if ({write_o, gnt} !== {exp_en, exp_addr, exp_data, GW'(exp_gnt)})
        $display("FAIL rnd_write[%0d]: got %h/%0d expected %b/%h/%h/%0d", cyc, write_o, gnt, exp_en, exp_addr, exp_data, exp_gnt);
      else passes++;
      if (write_o.enable === 1'b1) begin
        int s;
        s = int'(write_o.data[31:24]);
        checks++;
        if (s >= N) $display("FAIL rnd_sb_source[%0d]: got src %0d expected < %0d", cyc, s, N);
        else if (q[s].size() == 0) $display("FAIL rnd_sb_extra[%0d]: got write %h expected none", cyc, write_o.data);
        else if (q[s][0] !== write_o.data || gnt !== GW'(s))
          $display("FAIL rnd_sb_order[%0d]: got %h/%0d expected %h/%0d", cyc, write_o.data, gnt, q[s][0], s);
        else passes++;
        if (s < N && q[s].size() > 0) void'(q[s].pop_front());
      end
    end
    valid = '0; stall = 1'b0;
    tick();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (q[i].size() != int'(pending[i])) $display("FAIL rnd_drain[%0d]: got %0d outstanding expected %0d", i, q[i].size(), pending[i]);
      else passes++;
    end
    checks++;
    if (max_wait > N - 1) $display("FAIL rnd_max_wait: got %0d expected <= %0d", max_wait, N - 1);
    else passes++;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; valid = '0; addr = '0; data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_midstream();
    test_x0();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
